// File: rtl/whac_pkg.sv
// whac_pkg: shared types and constants for the whack-a-mole game blocks.
package whac_pkg;

    typedef enum logic [1:0] {IDLE, GAP, UP} state_t;

    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam int          NUM_HOLES_DEF = 6;

    // Right-shifting Galois step: the bit shifted out selects the tap mask.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ ({16{v[0]}} & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/mole_spawner_lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR, stepping every cycle after reset.
module lfsr16
    import whac_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] value
);

    logic [15:0] value_q;

    always_ff @(posedge clk) begin
        value_q <= reset ? SEED : lfsr_next(value_q);
    end

    assign value = value_q;

endmodule

// File: rtl/mole_spawner.sv
// mole_spawner: spawns mole patterns, knocks them down on hits, reports round outcomes.
module mole_spawner
    import whac_pkg::*;
#(
    parameter int          NUM_HOLES    = NUM_HOLES_DEF,
    parameter int          GAP_CYCLES   = 25_000_000,
    parameter int          UP_TIME_INIT = 50_000_000,
    parameter int          UP_TIME_MIN  = 12_500_000,
    parameter int          UP_TIME_STEP = 2_500_000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 game_in_progress,
    input  logic [NUM_HOLES-1:0] hit_holes,
    output logic [NUM_HOLES-1:0] mole_positions,
    output logic                 round_cleared,
    output logic                 round_timeout
);

    localparam int GW = $clog2(GAP_CYCLES) + 1;
    localparam int UW = $clog2(UP_TIME_INIT) + 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    state_t               state_q, state_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [UW-1:0]        up_cnt_q, up_cnt_d;
    logic [UW-1:0]        up_time_q, up_time_d;
    logic [NUM_HOLES-1:0] moles_q, moles_d;
    logic                 clr_q, clr_d;
    logic                 to_q, to_d;
    logic [15:0]          lfsr;
    logic [NUM_HOLES-1:0] slice, pattern, hit_left;
    logic [UW-1:0]        next_up;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .value (lfsr)
    );

    // An empty slice would spawn an invisible round, so fall back to hole 0.
    assign slice    = NUM_HOLES'(lfsr);
    assign pattern  = (slice == '0) ? NUM_HOLES'(1) : slice;
    assign hit_left = moles_q & ~hit_holes;
    assign next_up  = (32'(up_time_q) >= UP_TIME_MIN + UP_TIME_STEP)
                    ? UW'(32'(up_time_q) - UP_TIME_STEP) : UW'(UP_TIME_MIN);

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        up_cnt_d  = up_cnt_q;
        up_time_d = up_time_q;
        moles_d   = moles_q;
        clr_d     = 1'b0;
        to_d      = 1'b0;
        case (state_q)
            IDLE: begin
                up_time_d = UW'(UP_TIME_INIT);
                if (game_in_progress) begin
                    state_d = GAP;
                    gap_d   = GAP_LAST;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d  = UP;
                    moles_d  = pattern;
                    up_cnt_d = up_time_q - 1'b1;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            UP: begin
                // Hits land before the expiry check so a last-cycle clear still counts.
                moles_d = hit_left;
                if (hit_left == '0) begin
                    clr_d     = 1'b1;
                    up_time_d = next_up;
                    state_d   = GAP;
                    gap_d     = GAP_LAST;
                end else if (up_cnt_q == '0) begin
                    moles_d = '0;
                    to_d    = 1'b1;
                    state_d = GAP;
                    gap_d   = GAP_LAST;
                end else begin
                    up_cnt_d = up_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!game_in_progress) begin
            state_d = IDLE;
            moles_d = '0;
            clr_d   = 1'b0;
            to_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            gap_q     <= '0;
            up_cnt_q  <= '0;
            up_time_q <= UW'(UP_TIME_INIT);
            moles_q   <= '0;
            clr_q     <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            up_cnt_q  <= up_cnt_d;
            up_time_q <= up_time_d;
            moles_q   <= moles_d;
            clr_q     <= clr_d;
            to_q      <= to_d;
        end
    end

    assign mole_positions = moles_q;
    assign round_cleared  = clr_q;
    assign round_timeout  = to_q;

endmodule

// File: tb/tb_mole_spawner.sv
// tb_mole_spawner: scoreboard bench; stimulus queues expected output events, a monitor checks them.
module tb_mole_spawner;

    localparam int NH = 6;

    typedef struct {
        int          c;
        logic [NH-1:0] m;
        logic        clr;
        logic        to;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          gip = 1'b0;
    logic [NH-1:0] hits = '0;
    logic [NH-1:0] moles;
    logic          clr, to;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    logic [15:0]   model_lfsr;
    logic [NH-1:0] prev_m = '0;
    ev_t           q[$];
    ev_t           e;

    mole_spawner #(
        .NUM_HOLES    (NH),
        .GAP_CYCLES   (4),
        .UP_TIME_INIT (8),
        .UP_TIME_MIN  (4),
        .UP_TIME_STEP (3),
        .LFSR_SEED    (16'hACE1)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .game_in_progress (gip),
        .hit_holes        (hits),
        .mole_positions   (moles),
        .round_cleared    (clr),
        .round_timeout    (to)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        model_lfsr <= reset ? 16'hACE1 : step(model_lfsr);
    end

    // Expected spawn pattern for a spawn on edge s, seen from the current cycle.
    function automatic logic [NH-1:0] pat_at(input int s);
        logic [15:0] v;
        v = model_lfsr;
        for (int i = 0; i < s - 1 - cyc; i++) v = step(v);
        return (v[NH-1:0] == '0) ? NH'(1) : v[NH-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push(input int c, input logic [NH-1:0] m, input logic cl, input logic t);
        ev_t x;
        x.c = c;
        x.m = m;
        x.clr = cl;
        x.to = t;
        q.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // mode 0: no hits; 1: stray then one mole per cycle; 2: stray plus partial clear;
    // 3: all moles in one hit; 4: last mole hit on the final up cycle.
    task automatic round(input int s, input int up, input int mode, output int fin);
        logic [NH-1:0] p, m, nm, lo_bit;
        logic [NH-1:0] hv[16];
        int j;
        p = pat_at(s);
        for (int k = 0; k < 16; k++) hv[k] = '0;
        lo_bit = p & (~p + NH'(1));
        case (mode)
            1: begin
                hv[0] = ~p;
                j = 1;
                for (int i = 0; i < NH; i++) if (p[i]) begin
                    hv[j] = (NH'(1) << i) | ~p;
                    j++;
                end
            end
            2: begin
                hv[0] = ~p;
                hv[1] = ((p & ~lo_bit) != '0) ? (lo_bit | ~p) : ~p;
            end
            3: hv[0] = p;
            4: begin
                hv[0] = p & ~lo_bit;
                hv[up-1] = lo_bit;
            end
            default: ;
        endcase
        push(s, p, 1'b0, 1'b0);
        fin = s + up;
        m = p;
        for (int k = 0; k < up; k++) begin
            nm = m & ~hv[k];
            if (nm == '0) begin
                push(s + k + 1, '0, 1'b1, 1'b0);
                fin = s + k + 1;
                break;
            end
            if (k == up - 1) begin
                push(s + up, '0, 1'b0, 1'b1);
                break;
            end
            if (nm != m) push(s + k + 1, nm, 1'b0, 1'b0);
            m = nm;
        end
        wait_until(s);
        for (int k = 0; k < up && s + k < fin; k++) begin
            hits = hv[k];
            tick();
        end
        hits = '0;
        wait_until(fin);
    endtask

    always @(negedge clk) begin
        if (moles !== prev_m || clr === 1'b1 || to === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL event: unexpected at cycle %0d moles=%b clr=%b to=%b", cyc, moles, clr, to);
            end else begin
                e = q.pop_front();
                if (e.c != cyc || e.m !== moles || e.clr !== clr || e.to !== to) begin
                    errors++;
                    $display("FAIL event: got cycle=%0d moles=%b clr=%b to=%b, want cycle=%0d moles=%b clr=%b to=%b",
                             cyc, moles, clr, to, e.c, e.m, e.clr, e.to);
                end
            end
        end
        prev_m = moles;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, f;
        logic [NH-1:0] p;
        repeat (3) tick();
        chk("reset_moles", 32'(moles), 0);
        chk("reset_cleared", 32'(clr), 0);
        chk("reset_timeout", 32'(to), 0);
        reset = 1'b0;
        repeat (20) begin
            tick();
            chk("idle_outputs", 32'({moles, clr, to}), 0);
        end
        gip = 1'b1;
        t = cyc;
        round(t + 5, 8, 0, f);
        round(f + 4, 8, 0, f);
        round(f + 4, 8, 1, f);
        round(f + 4, 5, 2, f);
        round(f + 4, 5, 4, f);
        round(f + 4, 4, 0, f);
        round(f + 4, 4, 3, f);
        round(f + 4, 4, 0, f);
        t = f + 4;
        p = pat_at(t);
        push(t, p, 1'b0, 1'b0);
        push(t + 2, '0, 1'b0, 1'b0);
        wait_until(t + 1);
        gip = 1'b0;
        tick();
        tick();
        chk("abort_moles", 32'(moles), 0);
        tick();
        gip = 1'b1;
        t = cyc;
        round(t + 5, 8, 0, f);
        wait_until(f + 2);
        reset = 1'b1;
        tick();
        chk("midgap_reset_moles", 32'(moles), 0);
        chk("midgap_reset_pulses", 32'({clr, to}), 0);
        reset = 1'b0;
        t = cyc;
        round(t + 5, 8, 0, f);
        repeat (3) tick();
        chk("queue_empty", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
